// File: rtl/sub_nbit_serial.sv
// Bit-serial N-bit unsigned subtractor: computes a - b one bit per clock, LSB first,
// with a start/busy/done handshake and an N+1-bit two's-complement result that holds.
module sub_nbit_serial #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N:0]   diff,
    output logic         borrow
);

    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [N-1:0]       a_sh_reg, a_sh_next;
    logic [N-1:0]       b_sh_reg, b_sh_next;
    logic [N-2:0]       r_reg, r_next;
    logic               br_reg, br_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [N:0]         diff_reg, diff_next;
    logic               borrow_reg, borrow_next;
    logic               done_reg, done_next;

    logic               bit_d;
    logic               br_calc;
    logic               last_bit;
    logic [N-1:0]       a_shift;
    logic [N-1:0]       b_shift;
    logic [N-2:0]       r_shift;

    // One full-subtractor cell, reused for every bit position over time.
    assign bit_d    = a_sh_reg[0] ^ b_sh_reg[0] ^ br_reg;
    assign br_calc  = (~a_sh_reg[0] & b_sh_reg[0]) | (~(a_sh_reg[0] ^ b_sh_reg[0]) & br_reg);
    assign last_bit = (cnt_reg == CNT_W'(N - 1));

    // Operand shifters: zero fills from the top as bits are consumed.
    generate
        for (genvar gi = 0; gi < N - 1; gi++) begin : g_op_shift
            assign a_shift[gi] = a_sh_reg[gi + 1];
            assign b_shift[gi] = b_sh_reg[gi + 1];
        end
    endgenerate
    assign a_shift[N-1] = 1'b0;
    assign b_shift[N-1] = 1'b0;

    // R only keeps the N-1 completed bits; the Nth bit goes straight to diff on the
    // final edge. The loop is empty for N=2, where R is a single bit.
    generate
        for (genvar gi = 0; gi < N - 2; gi++) begin : g_r_shift
            assign r_shift[gi] = r_reg[gi + 1];
        end
    endgenerate
    assign r_shift[N-2] = bit_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            r_reg      <= '0;
            br_reg     <= 1'b0;
            cnt_reg    <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_sh_reg   <= a_sh_next;
            b_sh_reg   <= b_sh_next;
            r_reg      <= r_next;
            br_reg     <= br_next;
            cnt_reg    <= cnt_next;
            diff_reg   <= diff_next;
            borrow_reg <= borrow_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        a_sh_next   = a_sh_reg;
        b_sh_next   = b_sh_reg;
        r_next      = r_reg;
        br_next     = br_reg;
        cnt_next    = cnt_reg;
        diff_next   = diff_reg;
        borrow_next = borrow_reg;
        done_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_sh_next  = a;
                    b_sh_next  = b;
                    r_next     = '0;
                    br_next    = 1'b0;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                a_sh_next = a_shift;
                b_sh_next = b_shift;
                r_next    = r_shift;
                br_next   = br_calc;
                cnt_next  = cnt_reg + 1'b1;
                // Result registers update only here, so partial results never show.
                if (last_bit) begin
                    diff_next   = {br_calc, bit_d, r_reg};
                    borrow_next = br_calc;
                    done_next   = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy   = (state_reg == RUN);
    assign done   = done_reg;
    assign diff   = diff_reg;
    assign borrow = borrow_reg;

endmodule

// File: tb/tb_sub_nbit_serial.sv
// Directed and random checks of the bit-serial subtractor: reset, latency,
// arithmetic, ignored start while busy, back-to-back starts and mid-run reset.
module tb_sub_nbit_serial;

    localparam int N = 10;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N:0]   diff;
    logic         borrow;

    int tests;
    int fails;

    sub_nbit_serial #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one start and wait (bounded) for done; all sampling is 1 time unit after the edge.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                          output int lat, output int busy_cycles);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy_cycles = 0;
        while (lat < 40) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow !== 1'b0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b diff=%h borrow=%b, required 0 0 000 0",
                     busy, done, diff, borrow);
        end
        // rst and start together: rst wins
        start = 1'b1; a = 10'd5; b = 10'd1;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_beats_start: busy=%b, required 0", busy);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_zero;
        int lat, bc;
        run_op(10'd0, 10'd0, lat, bc);
        tests++;
        if (lat !== N || bc !== N) begin
            fails++;
            $display("FAIL zero_latency: latency=%0d busy_cycles=%0d, required %0d %0d", lat, bc, N, N);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_in_done: busy=%b, required 0", busy);
        end
        tests++;
        if (diff !== 11'h000 || borrow !== 1'b0) begin
            fails++;
            $display("FAIL zero_result: diff=%h borrow=%b, required 000 0", diff, borrow);
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0 || diff !== 11'h000) begin
            fails++;
            $display("FAIL done_one_cycle: done=%b diff=%h, required 0 000", done, diff);
        end
        $display("[TB] 0-0 -> diff=%h borrow=%b latency=%0d", diff, borrow, lat);
    endtask

    task automatic test_directed;
        logic [N-1:0] va [5];
        logic [N-1:0] vb [5];
        logic [N:0]   vd [5];
        logic         vbr[5];
        int lat, bc;
        va[0] = 10'd28;   vb[0] = 10'd12;   vd[0] = 11'h010; vbr[0] = 1'b0;
        va[1] = 10'd12;   vb[1] = 10'd28;   vd[1] = 11'h7F0; vbr[1] = 1'b1;
        va[2] = 10'd1023; vb[2] = 10'd0;    vd[2] = 11'h3FF; vbr[2] = 1'b0;
        va[3] = 10'd0;    vb[3] = 10'd1023; vd[3] = 11'h401; vbr[3] = 1'b1;
        va[4] = 10'd1023; vb[4] = 10'd1023; vd[4] = 11'h000; vbr[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], lat, bc);
            tests++;
            if (lat !== N || diff !== vd[i] || borrow !== vbr[i]) begin
                fails++;
                $display("FAIL directed_%0d: a=%0d b=%0d latency=%0d diff=%h borrow=%b, required latency=%0d diff=%h borrow=%b",
                         i, va[i], vb[i], lat, diff, borrow, N, vd[i], vbr[i]);
            end
            $display("[TB] %0d-%0d -> diff=%h borrow=%b", va[i], vb[i], diff, borrow);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        int dones;
        int gap;
        // first op 100-30; hammer start and operands while busy
        start = 1'b1; a = 10'd100; b = 10'd30;
        @(posedge clk); #1;
        dones = 0;
        for (int c = 1; c <= N; c++) begin
            start = 1'b1; a = 10'(c * 37); b = 10'(c * 91);
            @(posedge clk); #1;
            if (done) dones++;
            if (c < N && done) break;
        end
        tests++;
        if (dones !== 1 || done !== 1'b1 || diff !== 11'h046 || borrow !== 1'b0) begin
            fails++;
            $display("FAIL busy_ignore: dones=%0d done=%b diff=%h borrow=%b, required 1 1 046 0",
                     dones, done, diff, borrow);
        end
        $display("[TB] 100-30 with start held while busy -> diff=%h", diff);
        // start in the done cycle must be accepted
        start = 1'b1; a = 10'd5; b = 10'd3;
        gap = 0;
        dones = 0;
        while (gap < 40) begin
            @(posedge clk); #1;
            start = 1'b0;
            gap++;
            if (done) begin
                dones++;
                break;
            end
        end
        tests++;
        if (gap !== N + 1 || diff !== 11'h002 || borrow !== 1'b0) begin
            fails++;
            $display("FAIL back_to_back: gap=%0d diff=%h borrow=%b, required %0d 002 0",
                     gap, diff, borrow, N + 1);
        end
        $display("[TB] 5-3 back-to-back -> diff=%h gap=%0d", diff, gap);
        @(posedge clk); #1;
    endtask

    task automatic test_midrun_reset;
        int lat, bc, dones;
        start = 1'b1; a = 10'd700; b = 10'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow !== 1'b0) begin
            fails++;
            $display("FAIL midrun_reset: busy=%b done=%b diff=%h borrow=%b, required 0 0 000 0",
                     busy, done, diff, borrow);
        end
        dones = 0;
        for (int c = 0; c < N + 2; c++) begin
            @(posedge clk); #1;
            if (done || diff !== '0) dones++;
        end
        tests++;
        if (dones !== 0) begin
            fails++;
            $display("FAIL abort_no_done: stray_cycles=%0d, required 0", dones);
        end
        run_op(10'd120, 10'd68, lat, bc);
        tests++;
        if (lat !== N || diff !== 11'd52 || borrow !== 1'b0) begin
            fails++;
            $display("FAIL after_reset: latency=%0d diff=%h borrow=%b, required %0d 034 0",
                     lat, diff, borrow, N);
        end
        $display("[TB] mid-run reset then 120-68 -> diff=%h", diff);
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic [N-1:0] ra, rb;
        logic [N:0]   exp_d;
        int lat, bc, bad;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = N'($urandom_range(0, (1 << N) - 1));
            rb = N'($urandom_range(0, (1 << N) - 1));
            exp_d = {1'b0, ra} - {1'b0, rb};
            run_op(ra, rb, lat, bc);
            tests++;
            if (lat !== N || diff !== exp_d || borrow !== (ra < rb)) begin
                fails++;
                bad++;
                $display("FAIL random_%0d: a=%0d b=%0d latency=%0d diff=%h borrow=%b, required %0d %h %b",
                         i, ra, rb, lat, diff, borrow, N, exp_d, (ra < rb));
            end
            @(posedge clk); #1;
            tests++;
            if (done !== 1'b0) begin
                fails++;
                $display("FAIL random_pulse_%0d: done=%b one cycle after pulse, required 0", i, done);
            end
        end
        $display("[TB] random sweep of 1000 pairs, %0d bad", bad);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_zero();
        test_directed();
        test_back_to_back();
        test_midrun_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
